// File: rtl/mem_cmd_seq.sv
// Byte-stream command sequencer feeding a small DFF memory: decodes write/read commands,
// strobes the memory and returns read data on a valid/ready stream. Option: MEM_CMD_SEQ_WRITE_ACK_EN.
module mem_cmd_seq #(
    parameter int ADDR_BITS   = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_wr_en,
    output logic                 mem_r_en,
    output logic [7:0]           mem_wdata,
    input  logic [7:0]           mem_rdata,
    output logic                 busy,
    output logic                 err
);

    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        GET_DATA,
        WRITE,
        READ,
        WAIT_RD,
        RESP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] tmo_cnt;
    logic             accept;

    // Strobes are gated with rst so a reset edge can never coincide with a memory access.
    assign in_ready  = !rst && ((state == IDLE) || (state == GET_DATA));
    assign mem_wr_en = !rst && (state == WRITE);
    assign mem_r_en  = !rst && (state == READ);
    assign out_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            out_data  <= '0;
            err       <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (in_data[7:6])
                            2'b10: begin
                                mem_addr <= in_data[ADDR_BITS-1:0];
                                tmo_cnt  <= '0;
                                state    <= GET_DATA;
                            end
                            2'b01: begin
                                mem_addr <= in_data[ADDR_BITS-1:0];
                                state    <= READ;
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                end
                GET_DATA: begin
                    if (accept) begin
                        mem_wdata <= in_data;
                        state     <= WRITE;
                    end else if ((TIMEOUT_CYC != 0) && (tmo_cnt == TMO_LAST)) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else if (tmo_cnt != {CNT_W{1'b1}}) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                WRITE: begin
`ifdef MEM_CMD_SEQ_WRITE_ACK_EN
                    out_data <= 8'hA0 | 8'(mem_addr);
                    state    <= RESP;
`else
                    state    <= IDLE;
`endif
                end
                READ: begin
                    state <= WAIT_RD;
                end
                WAIT_RD: begin
                    // The memory registers its read data on the READ edge, so it is valid here.
                    out_data <= mem_rdata;
                    state    <= RESP;
                end
                RESP: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_cmd_seq.sv
// Directed bench for mem_cmd_seq with a behavioural 16-byte memory and an output scoreboard.
module tb_mem_cmd_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] mem_addr;
    logic       mem_wr_en;
    logic       mem_r_en;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       err;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    int rd_cnt   = 0;
    int err_cnt  = 0;
    int base_wr, base_rd, base_err;

    logic [7:0] exp_q[$];
    logic [7:0] mem[16];
    logic       mem_loaded = 1'b0;

    mem_cmd_seq #(.ADDR_BITS(4), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_r_en(mem_r_en),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Memory model: registered read, contents i -> 0x10+i except address 7 holding 0x3C.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h10 + 8'(i);
            mem[7]     <= 8'h3C;
            mem_loaded <= 1'b1;
        end else begin
            if (mem_wr_en) mem[mem_addr] <= mem_wdata;
            if (mem_r_en) mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Mid-cycle monitor: strobe/err counting and scoreboard pop on each output transfer.
    always @(negedge clk) begin
        if (mem_wr_en) wr_cnt++;
        if (mem_r_en) rd_cnt++;
        if (mem_wr_en && mem_r_en) check("strobes_exclusive", 1, 0);
        if (err) err_cnt++;
        if (out_valid && out_ready && !rst) begin
            check("sb_has_expect", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("sb_out_data", out_data, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("send_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        check("out_valid_arrives", out_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        tick(); tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_out_data", out_data, 0);
        check("rst_strobes", {mem_wr_en, mem_r_en}, 0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Write 0x5A to address 3, then read it back.
        send(8'h83);
        send(8'h5A);
        check("wr_strobe", mem_wr_en, 1);
        check("wr_addr", mem_addr, 3);
        check("wr_data", mem_wdata, 8'h5A);
        check("wr_no_read", mem_r_en, 0);
`ifdef MEM_CMD_SEQ_WRITE_ACK_EN
        exp_q.push_back(8'hA3);
`endif
        tick();
        check("wr_strobe_one_cycle", mem_wr_en, 0);
        exp_q.push_back(8'h5A);
        send(8'h43);
        check("rd_strobe", mem_r_en, 1);
        check("rd_addr", mem_addr, 3);
        check("rd_n1_no_valid", out_valid, 0);
        tick();
        check("rd_strobe_one_cycle", mem_r_en, 0);
        check("rd_n2_no_valid", out_valid, 0);
        tick();
        check("rd_n3_valid", out_valid, 1);
        check("rd_n3_data", out_data, 8'h5A);
        tick();
        check("rd_done_idle", busy, 0);
        check("rd_q_empty", exp_q.size(), 0);
        check("wr_count_1", wr_cnt, 1);
        check("rd_count_1", rd_cnt, 1);

        // Invalid commands 0xC2 and 0x05.
        base_wr = wr_cnt; base_rd = rd_cnt; base_err = err_cnt;
        send(8'hC2);
        check("inv1_err", err, 1);
        check("inv1_busy", busy, 0);
        check("inv1_in_ready", in_ready, 1);
        send(8'h05);
        check("inv2_err", err, 1);
        check("inv2_busy", busy, 0);
        tick();
        check("inv_err_clear", err, 0);
        check("inv_err_count", err_cnt - base_err, 2);
        check("inv_no_wr", wr_cnt - base_wr, 0);
        check("inv_no_rd", rd_cnt - base_rd, 0);

        // Backpressure on a read of address 7.
        out_ready = 1'b0;
        exp_q.push_back(8'h3C);
        send(8'h47);
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, 8'h3C);
            check("bp_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        check("bp_valid_last", out_valid, 1);
        tick();
        check("bp_done_valid", out_valid, 0);
        check("bp_done_busy", busy, 0);
        check("bp_q_empty", exp_q.size(), 0);

        // Write-data timeout after 4 idle cycles.
        base_wr = wr_cnt; base_err = err_cnt;
        send(8'h81);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("tmo_wait_err", err, 0);
            check("tmo_wait_busy", busy, 1);
        end
        tick();
        check("tmo_err", err, 1);
        check("tmo_idle", busy, 0);
        check("tmo_no_wr", wr_cnt - base_wr, 0);
        exp_q.push_back(8'h11);
        send(8'h41);
        wait_out();
        check("tmo_rd_data", out_data, 8'h11);
        tick();
        check("tmo_err_count", err_cnt - base_err, 1);

        // Reset during WRITE.
        base_wr = wr_cnt;
        send(8'h82);
        send(8'h77);
        rst = 1'b1;
        #1;
        check("rstw_no_strobe", mem_wr_en, 0);
        tick();
        rst = 1'b0;
        #1;
        check("rstw_out_valid", out_valid, 0);
        check("rstw_in_ready", in_ready, 1);
        check("rstw_busy", busy, 0);
        check("rstw_no_wr", wr_cnt - base_wr, 0);

        // Reset during RESP: response dropped.
        out_ready = 1'b0;
        send(8'h45);
        tick(); tick();
        check("rstr_valid", out_valid, 1);
        check("rstr_data", out_data, 8'h15);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rstr_out_valid", out_valid, 0);
        check("rstr_in_ready", in_ready, 1);
        out_ready = 1'b1;
        exp_q.push_back(8'h12);
        send(8'h42);
        wait_out();
        check("rstw_mem_untouched", out_data, 8'h12);
        tick();

        // Write to address 12: ack byte only when the option is built in.
        send(8'h8C);
        send(8'h11);
        check("ack_wr_strobe", mem_wr_en, 1);
        check("ack_wr_addr", mem_addr, 4'hC);
        check("ack_wr_data", mem_wdata, 8'h11);
`ifdef MEM_CMD_SEQ_WRITE_ACK_EN
        exp_q.push_back(8'hAC);
        tick();
        check("ack_valid", out_valid, 1);
        check("ack_data", out_data, 8'hAC);
        tick();
`else
        for (int i = 0; i < 4; i++) begin
            tick();
            check("noack_valid", out_valid, 0);
        end
`endif
        check("end_busy", busy, 0);
        check("end_q_empty", exp_q.size(), 0);
        check("end_wr_count", wr_cnt, 2);
        check("end_rd_count", rd_cnt, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
